// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline sequencing logic: controller states and
// default register-index width / SRAM wait limit.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  localparam int REG_W_DEF       = 4;
  localparam int MEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Read-after-write hazard detection for the ID-stage instruction against the
// instructions in EXE and MEM. Purely combinational.
module hazard_detect
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             i_forward_en,
  input  logic             i_use_src1,
  input  logic             i_two_src,
  input  logic [REG_W-1:0] i_src1,
  input  logic [REG_W-1:0] i_src2,
  input  logic [REG_W-1:0] i_exe_dest,
  input  logic             i_exe_wb_en,
  input  logic             i_exe_mem_read,
  input  logic [REG_W-1:0] i_mem_dest,
  input  logic             i_mem_wb_en,
  output logic             o_hz
);

  logic w_exe_match;
  logic w_mem_match;

  assign w_exe_match = (i_use_src1 & (i_src1 == i_exe_dest)) |
                       (i_two_src  & (i_src2 == i_exe_dest));
  assign w_mem_match = (i_use_src1 & (i_src1 == i_mem_dest)) |
                       (i_two_src  & (i_src2 == i_mem_dest));

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign o_hz = i_forward_en ? (i_exe_mem_read & w_exe_match)
                             : ((i_exe_wb_en & w_exe_match) | (i_mem_wb_en & w_mem_match));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing: IF/ID hold, ID/EX bubbles, branch squash, SRAM-wait
// freeze with timeout fault, and a saturating stall-cycle counter.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16,
  parameter int REG_W       = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic             use_src1,
  input  logic             two_src,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_access_req,
  input  logic             sram_ready,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             freeze_pipe,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int              WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TMO  = WC_W'(MEM_TIMEOUT);

  state_e           r_state;
  logic [WC_W-1:0]  r_wait_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_hz;
  logic w_id_rules;
  logic w_freeze_if_id;
  logic w_flush_if_id;
  logic w_flush_id_ex;
  logic w_freeze_pipe;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .i_forward_en   (forward_en),
    .i_use_src1     (use_src1),
    .i_two_src      (two_src),
    .i_src1         (src1),
    .i_src2         (src2),
    .i_exe_dest     (exe_dest),
    .i_exe_wb_en    (exe_wb_en),
    .i_exe_mem_read (exe_mem_read),
    .i_mem_dest     (mem_dest),
    .i_mem_wb_en    (mem_wb_en),
    .o_hz           (w_hz)
  );

  // w_id_rules: pipeline is moving this cycle, so branch/hazard handling applies.
  always_comb begin
    w_id_rules     = 1'b0;
    w_freeze_if_id = 1'b0;
    w_flush_if_id  = 1'b0;
    w_flush_id_ex  = 1'b0;
    w_freeze_pipe  = 1'b0;
    case (r_state)
      RUN: begin
        if (mem_access_req & ~sram_ready) w_freeze_pipe = 1'b1;
        else                              w_id_rules    = 1'b1;
      end
      MEM_WAIT: begin
        if (~sram_ready) w_freeze_pipe = 1'b1;
        else             w_id_rules    = 1'b1;
      end
      default: w_freeze_pipe = 1'b1;
    endcase
    if (w_id_rules) begin
      if (branch_taken) begin
        w_flush_if_id = 1'b1;
        w_flush_id_ex = 1'b1;
      end else if (w_hz) begin
        w_freeze_if_id = 1'b1;
        w_flush_id_ex  = 1'b1;
      end
    end
  end

  assign freeze_if_id = w_freeze_if_id & ~rst;
  assign flush_if_id  = w_flush_if_id  & ~rst;
  assign flush_id_ex  = w_flush_id_ex  & ~rst;
  assign freeze_pipe  = w_freeze_pipe  & ~rst;
  assign mem_timeout  = r_mem_timeout;
  assign stall_cycles = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (mem_access_req & ~sram_ready) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (sram_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == TMO) begin
            r_state       <= FAULT;
            r_mem_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WC_W'(1);
          end
        end
        default: r_state <= FAULT;
      endcase
      if ((w_freeze_pipe | w_freeze_if_id) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized + directed bench for pipeline_hazard_controller against a
// cycle-level behavioural model; two instances differ only in counter width.
module tb_pipeline_hazard_controller;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       forward_en, use_src1, two_src;
  logic [3:0] src1, src2, exe_dest, mem_dest;
  logic       exe_wb_en, exe_mem_read, mem_wb_en;
  logic       branch_taken, mem_access_req, sram_ready;

  logic        a_fz, a_ff, a_fe, a_fp, a_tmo;
  logic [15:0] a_stall;
  logic        b_fz, b_ff, b_fe, b_fp, b_tmo;
  logic [3:0]  b_stall;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MEM_TIMEOUT(TMO), .CNT_W(16), .REG_W(4)) dut_a (
    .clk(clk), .rst(rst), .forward_en(forward_en), .use_src1(use_src1), .two_src(two_src),
    .src1(src1), .src2(src2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_access_req(mem_access_req), .sram_ready(sram_ready),
    .freeze_if_id(a_fz), .flush_if_id(a_ff), .flush_id_ex(a_fe), .freeze_pipe(a_fp),
    .mem_timeout(a_tmo), .stall_cycles(a_stall)
  );

  pipeline_hazard_controller #(.MEM_TIMEOUT(TMO), .CNT_W(4), .REG_W(4)) dut_b (
    .clk(clk), .rst(rst), .forward_en(forward_en), .use_src1(use_src1), .two_src(two_src),
    .src1(src1), .src2(src2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_access_req(mem_access_req), .sram_ready(sram_ready),
    .freeze_if_id(b_fz), .flush_if_id(b_ff), .flush_id_ex(b_fe), .freeze_pipe(b_fp),
    .mem_timeout(b_tmo), .stall_cycles(b_stall)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: 0 = running, 1 = waiting on SRAM, 2 = faulted
  int m_mode, m_wait, m_stall, m_stall4;

  function automatic bit reads(input logic [3:0] r);
    return (use_src1 && src1 == r) || (two_src && src2 == r);
  endfunction

  function automatic bit m_hz();
    if (forward_en) return exe_mem_read && reads(exe_dest);
    return (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
  endfunction

  task automatic idle();
    forward_en = 0; use_src1 = 0; two_src = 0; src1 = 0; src2 = 0;
    exe_dest = 0; mem_dest = 0; exe_wb_en = 0; exe_mem_read = 0; mem_wb_en = 0;
    branch_taken = 0; mem_access_req = 0; sram_ready = 0;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance it.
  task automatic cyc(input string tag);
    bit fz, ff, fe, fp, moving;
    @(negedge clk);
    fz = 0; ff = 0; fe = 0; fp = 0; moving = 0;
    if (!rst) begin
      if (m_mode == 0)      begin if (mem_access_req && !sram_ready) fp = 1; else moving = 1; end
      else if (m_mode == 1) begin if (!sram_ready) fp = 1; else moving = 1; end
      else fp = 1;
      if (moving) begin
        if (branch_taken) begin ff = 1; fe = 1; end
        else if (m_hz()) begin fz = 1; fe = 1; end
      end
    end
    chk({tag, ":ctl"}, 32'({a_fz, a_ff, a_fe, a_fp, b_fz, b_ff, b_fe, b_fp}),
        32'({fz, ff, fe, fp, fz, ff, fe, fp}));
    chk({tag, ":tmo"}, 32'({a_tmo, b_tmo}), (!rst && m_mode == 2) ? 32'h3 : 32'h0);
    chk({tag, ":stall16"}, 32'(a_stall), rst ? 0 : 32'(m_stall));
    chk({tag, ":stall4"}, 32'(b_stall), rst ? 0 : 32'(m_stall4));
    if (rst) begin
      m_mode = 0; m_wait = 0; m_stall = 0; m_stall4 = 0;
    end else begin
      if (fp || fz) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (m_mode == 0) begin
        if (mem_access_req && !sram_ready) begin m_mode = 1; m_wait = 1; end
      end else if (m_mode == 1) begin
        if (sram_ready) begin m_mode = 0; m_wait = 0; end
        else if (m_wait == TMO) m_mode = 2;
        else m_wait++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc("rst");
    rst = 0;
  endtask

  initial begin
    int phase_slow;
    rst = 1;
    idle();
    m_mode = 0; m_wait = 0; m_stall = 0; m_stall4 = 0;
    #2;
    chk("por_outputs", 32'({a_fz, a_ff, a_fe, a_fp, a_tmo, a_stall}), 32'h0);
    @(posedge clk); #1;
    cyc("rst0");
    rst = 0;

    // Scenario 1: EXE writes src1, no forwarding
    use_src1 = 1; src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1;
    #2 chk("s1_hz", 32'({a_fz, a_ff, a_fe}), 32'b101);
    cyc("s1a");
    exe_wb_en = 0;
    cyc("s1b");
    chk("s1_stall", 32'(a_stall), 32'd1);

    // Scenario 2: forwarding covers ALU result, not a load
    idle();
    forward_en = 1; two_src = 1; src2 = 4'd5; exe_dest = 4'd5; exe_wb_en = 1;
    #2 chk("s2_nostall", 32'({a_fz, a_fe}), 32'b00);
    cyc("s2a");
    exe_mem_read = 1;
    #2 chk("s2_load", 32'({a_fz, a_fe}), 32'b11);
    cyc("s2b");
    exe_mem_read = 0;
    cyc("s2c");

    // Scenario 3: branch squashes the hazarding instruction
    idle();
    use_src1 = 1; src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1; branch_taken = 1;
    #2 chk("s3_branch", 32'({a_fz, a_ff, a_fe}), 32'b011);
    cyc("s3");

    // Scenario 4: four-cycle SRAM wait
    do_reset();
    mem_access_req = 1;
    for (int i = 0; i < 4; i++) cyc("s4_wait");
    sram_ready = 1;
    #2 chk("s4_ready", 32'(a_fp), 32'd0);
    cyc("s4_rdy");
    idle();
    cyc("s4_post");
    chk("s4_stall", 32'(a_stall), 32'd4);

    // Scenario 5: timeout into FAULT, then reset out of it
    do_reset();
    mem_access_req = 1;
    for (int i = 0; i < 8; i++) cyc("s5_wait");
    chk("s5_pre_tmo", 32'(a_tmo), 32'd0);
    cyc("s5_last");
    chk("s5_tmo", 32'(a_tmo), 32'd1);
    mem_access_req = 0;
    sram_ready = 1;
    for (int i = 0; i < 3; i++) cyc("s5_fault");
    rst = 1;
    #1 chk("s5_rst_async", 32'({a_fz, a_ff, a_fe, a_fp, a_tmo, a_stall}), 32'h0);
    cyc("s5_rst");
    rst = 0;
    idle();
    cyc("s5_run");

    // Scenario 6: long hazard saturates the narrow counter
    do_reset();
    use_src1 = 1; src1 = 4'd7; mem_dest = 4'd7; mem_wb_en = 1;
    for (int i = 0; i < 20; i++) cyc("s6");
    chk("s6_sat4", 32'(b_stall), 32'hF);
    chk("s6_cnt16", 32'(a_stall), 32'd20);

    // Randomized traffic; some phases keep SRAM slow enough to time out
    phase_slow = 0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 40 == 0) phase_slow = ($urandom_range(0, 2) == 0) ? 1 : 0;
      forward_en     = 1'($urandom_range(0, 1));
      use_src1       = 1'($urandom_range(0, 1));
      two_src        = 1'($urandom_range(0, 1));
      src1           = 4'($urandom_range(0, 3));
      src2           = 4'($urandom_range(0, 3));
      exe_dest       = 4'($urandom_range(0, 3));
      mem_dest       = 4'($urandom_range(0, 3));
      exe_wb_en      = 1'($urandom_range(0, 1));
      exe_mem_read   = 1'($urandom_range(0, 1));
      mem_wb_en      = 1'($urandom_range(0, 1));
      branch_taken   = 1'($urandom_range(0, 4) == 0);
      mem_access_req = 1'($urandom_range(0, 3) == 0);
      sram_ready     = phase_slow ? 1'($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
      rst            = 1'($urandom_range(0, 119) == 0);
      cyc("rnd");
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencing block for the 5-stage ARM-style pipeline.
- Decides each cycle whether the IF/ID register holds, whether a bubble goes into the ID/EX register (drives its `flush` input), and whether the whole pipeline freezes while SRAM is busy.
- Sources: decoded ID-stage operand info, EXE/MEM destination info, the EXE branch result and the SRAM ready handshake.
- Also keeps a memory-wait timeout FSM and a saturating stall-cycle counter.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before a fault.
- CNT_W, 16: width of stall_cycles.
- REG_W, 4: register index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- forward_en  in  1  forwarding unit enabled
- use_src1  in  1  ID instruction reads src1
- two_src  in  1  ID instruction reads src2
- src1  in  REG_W  ID Rn index
- src2  in  REG_W  ID Rm/Rd index
- exe_dest  in  REG_W  destination in ID/EX output
- exe_wb_en  in  1  EXE instruction writes back
- exe_mem_read  in  1  EXE instruction is a load
- mem_dest  in  REG_W  destination in EXE/MEM output
- mem_wb_en  in  1  MEM instruction writes back
- branch_taken  in  1  EXE resolved a taken branch
- mem_access_req  in  1  MEM stage issues SRAM read/write
- sram_ready  in  1  SRAM completes access this cycle
- freeze_if_id  out  1  hold PC and IF/ID register
- flush_if_id  out  1  zero IF/ID register
- flush_id_ex  out  1  bubble into ID/EX register
- freeze_pipe  out  1  hold all pipeline registers (memory wait)
- mem_timeout  out  1  sticky SRAM timeout fault
- stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- States: RUN, MEM_WAIT, FAULT.
  - The state register and a wait counter (width from clog2(MEM_TIMEOUT+1)) are async reset to RUN/0.
  - stall_cycles resets to 0; mem_timeout resets to 0.
  - While rst=1 all outputs are 0.
- Control outputs are combinational from state plus inputs (zero-latency Mealy). State, counters and mem_timeout update on posedge clk.
- Data hazard (hz):
  - m1 = use_src1 & (src1 == X)
  - m2 = two_src & (src2 == X)
  - forward_en=0: hz = (exe_wb_en & (m1|m2 with X=exe_dest)) | (mem_wb_en & (m1|m2 with X=mem_dest)).
  - forward_en=1: hz = exe_mem_read & (m1|m2 with X=exe_dest). MEM terms are ignored.
- RUN, priority high to low:
  - mem_access_req & ~sram_ready: freeze_pipe=1, all flushes=0, next state MEM_WAIT, wait counter <= 1.
  - branch_taken: flush_if_id=1, flush_id_ex=1, freeze_if_id=0. Branch wins over hz because the ID instruction is squashed.
  - hz: freeze_if_id=1, flush_id_ex=1 (one bubble per cycle; re-evaluated every cycle).
  - Otherwise all 0.
- MEM_WAIT:
  - freeze_pipe=1 while ~sram_ready; branch and hz are ignored and flushes forced 0.
  - On sram_ready: freeze_pipe=0 and RUN-rule branch/hz outputs apply in that same cycle; next state RUN; wait counter <= 0.
  - Otherwise the wait counter increments. When it equals MEM_TIMEOUT with ~sram_ready: next state FAULT, mem_timeout <= 1.
- FAULT: freeze_pipe=1, flushes 0, leaves only on rst.
- stall_cycles increments on every cycle with freeze_pipe | freeze_if_id. It saturates at all-ones with no wrap.
- mem_access_req deasserting while in MEM_WAIT (protocol violation) changes nothing; the controller waits for sram_ready.
- rst mid-wait: immediate return to RUN; counters and fault cleared.

Decomposition:
- Shared pipeline package holds:
  - the state enum (RUN=2'd0, MEM_WAIT=2'd1, FAULT=2'd2);
  - the REG_W default;
  - the MEM_TIMEOUT default constant.
- One natural sub-module, hazard_detect: purely combinational hz computation. The FSM, counters and output muxing stay in the top.

Test Plan:
1. forward_en=0, use_src1=1, src1=4'd3, exe_dest=4'd3, exe_wb_en=1 -> freeze_if_id=1, flush_id_ex=1 that cycle; after exe_wb_en=0, outputs 0 and stall_cycles=1.
2. forward_en=1, src2=4'd5, two_src=1, exe_dest=4'd5, exe_wb_en=1, exe_mem_read=0 -> no stall. Then exe_mem_read=1 -> one-cycle freeze_if_id plus flush_id_ex.
3. branch_taken=1 together with the hazard from scenario 1 -> flush_if_id=1, flush_id_ex=1, freeze_if_id=0.
4. mem_access_req=1, sram_ready low for 4 cycles, then 1 -> freeze_pipe=1 for exactly 4 cycles, 0 on the ready cycle, state back to RUN, stall_cycles=4.
5. MEM_TIMEOUT=8, sram_ready held 0 -> mem_timeout=1 after 8 wait cycles and freeze_pipe stays 1. Assert rst mid-FAULT -> all outputs 0 immediately, state RUN.
6. CNT_W=4, hold a hazard for 20 cycles -> stall_cycles stops at 4'hF.
